// File: rtl/dds_sweep_pkg.sv
// Shared definitions for the DDS frequency-sweep sequencer.
//
// Contents:
//   sweep_mode_e  - sweep mode codes as presented on cfg_mode
//   sweep_state_e - sequencer FSM state encoding
package dds_sweep_pkg;

    // Code 2'b11 is reserved and behaves exactly like a single sweep.
    typedef enum logic [1:0] {
        ModeSingle    = 2'b00,
        ModeSaw       = 2'b01,
        ModeTri       = 2'b10,
        ModeSingleAlt = 2'b11
    } sweep_mode_e;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StDwell = 3'd2,
        StStep  = 3'd3,
        StDone  = 3'd4,
        StHalt  = 3'd5
    } sweep_state_e;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep (chirp) sequencer for the sine DDS.
//
// Drives the DDS phase-load and phase-step AXI-stream inputs to produce stepped linear sweeps:
// a single sweep, a repeating sawtooth or a triangle. All cfg_* inputs are captured at start,
// so software may rewrite them while a sweep is running.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cfg_init_phase                 phase loaded into the DDS once at sweep start
//   cfg_start_step, cfg_stop_step  sweep end points (phase-step words)
//   cfg_delta                      unsigned increment between consecutive steps
//   cfg_dwell                      cycles spent on each step (0 behaves as 1)
//   cfg_mode                       00 single, 01 sawtooth, 10 triangle, 11 single
//   start, abort                   single-cycle control pulses
//   output_phase_*                 AXI-stream phase load towards the DDS
//   output_phase_step_*            AXI-stream phase step towards the DDS
//   busy                           high from start acceptance until back in idle
//   done                           one-cycle pulse at the normal end of a single sweep
//   cur_step                       last phase step accepted by the DDS
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PHASE_WIDTH-1:0] cfg_init_phase,
    input  logic [PHASE_WIDTH-1:0] cfg_start_step,
    input  logic [PHASE_WIDTH-1:0] cfg_stop_step,
    input  logic [PHASE_WIDTH-1:0] cfg_delta,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [1:0]             cfg_mode,
    input  logic                   start,
    input  logic                   abort,
    output logic [PHASE_WIDTH-1:0] output_phase_tdata,
    output logic                   output_phase_tvalid,
    input  logic                   output_phase_tready,
    output logic [PHASE_WIDTH-1:0] output_phase_step_tdata,
    output logic                   output_phase_step_tvalid,
    input  logic                   output_phase_step_tready,
    output logic                   busy,
    output logic                   done,
    output logic [PHASE_WIDTH-1:0] cur_step
);

    // One step of size delta from cur towards target. The extra MSB catches wrap-around in
    // either direction; overshooting or wrapping lands exactly on the target.
    function automatic logic [PHASE_WIDTH-1:0] step_toward(
        input logic [PHASE_WIDTH-1:0] cur,
        input logic [PHASE_WIDTH-1:0] delta,
        input logic [PHASE_WIDTH-1:0] target,
        input logic                   up
    );
        logic [PHASE_WIDTH:0] sum;
        logic                 clamp;
        if (up) begin
            sum   = {1'b0, cur} + {1'b0, delta};
            clamp = sum[PHASE_WIDTH] || (sum[PHASE_WIDTH-1:0] > target);
        end else begin
            sum   = {1'b0, cur} - {1'b0, delta};
            clamp = sum[PHASE_WIDTH] || (sum[PHASE_WIDTH-1:0] < target);
        end
        return clamp ? target : sum[PHASE_WIDTH-1:0];
    endfunction

    sweep_state_e           state_q, state_d;
    sweep_mode_e            mode_q, mode_d;
    logic [PHASE_WIDTH-1:0] init_phase_q, init_phase_d;
    logic [PHASE_WIDTH-1:0] start_step_q, start_step_d;
    logic [PHASE_WIDTH-1:0] stop_step_q, stop_step_d;
    logic [PHASE_WIDTH-1:0] delta_q, delta_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [PHASE_WIDTH-1:0] step_data_q, step_data_d;
    logic [PHASE_WIDTH-1:0] cur_step_q, cur_step_d;
    logic                   up_q, up_d;
    // rev_q set: the current leg heads back towards start_step (triangle return leg).
    logic                   rev_q, rev_d;
    logic                   phase_vld_q, phase_vld_d;
    logic                   step_vld_q, step_vld_d;
    // An abort seen while a transfer is outstanding, honoured once the transfer completes.
    logic                   abort_pend_q, abort_pend_d;

    logic                   phase_hs;
    logic                   step_hs;
    logic [PHASE_WIDTH-1:0] target;
    logic [PHASE_WIDTH-1:0] rev_target;
    logic [DWELL_WIDTH-1:0] dwell_init;
    logic                   at_target;
    logic [PHASE_WIDTH-1:0] next_fwd;
    logic [PHASE_WIDTH-1:0] next_rev;

    assign phase_hs   = phase_vld_q & output_phase_tready;
    assign step_hs    = step_vld_q & output_phase_step_tready;
    assign target     = rev_q ? start_step_q : stop_step_q;
    assign rev_target = rev_q ? stop_step_q : start_step_q;
    assign dwell_init = (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
    assign at_target  = (cur_step_q == target) || (delta_q == '0);
    assign next_fwd   = step_toward(cur_step_q, delta_q, target, up_q);
    assign next_rev   = step_toward(cur_step_q, delta_q, rev_target, !up_q);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        init_phase_d = init_phase_q;
        start_step_d = start_step_q;
        stop_step_d  = stop_step_q;
        delta_d      = delta_q;
        dwell_d      = dwell_q;
        cnt_d        = cnt_q;
        step_data_d  = step_data_q;
        cur_step_d   = cur_step_q;
        up_d         = up_q;
        rev_d        = rev_q;
        phase_vld_d  = phase_vld_q;
        step_vld_d   = step_vld_q;
        abort_pend_d = abort_pend_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    mode_d       = sweep_mode_e'(cfg_mode);
                    init_phase_d = cfg_init_phase;
                    start_step_d = cfg_start_step;
                    stop_step_d  = cfg_stop_step;
                    delta_d      = cfg_delta;
                    dwell_d      = cfg_dwell;
                    up_d         = (cfg_start_step <= cfg_stop_step);
                    rev_d        = 1'b0;
                    step_data_d  = cfg_start_step;
                    phase_vld_d  = 1'b1;
                    step_vld_d   = 1'b1;
                    abort_pend_d = 1'b0;
                    state_d      = StLoad;
                end
            end

            StLoad: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (phase_hs) begin
                    phase_vld_d = 1'b0;
                end
                if (step_hs) begin
                    step_vld_d = 1'b0;
                    cur_step_d = step_data_q;
                end
                if (!phase_vld_d && !step_vld_d) begin
                    if (abort || abort_pend_q) begin
                        state_d      = StHalt;
                        step_data_d  = '0;
                        step_vld_d   = 1'b1;
                        abort_pend_d = 1'b0;
                    end else begin
                        state_d = StDwell;
                        cnt_d   = dwell_init;
                    end
                end
            end

            StDwell: begin
                if (abort) begin
                    state_d     = StHalt;
                    step_data_d = '0;
                    step_vld_d  = 1'b1;
                end else if (cnt_q <= DWELL_WIDTH'(1)) begin
                    if (!at_target) begin
                        step_data_d = next_fwd;
                        step_vld_d  = 1'b1;
                        state_d     = StStep;
                    end else begin
                        case (mode_q)
                            ModeSaw: begin
                                // Phase accumulator keeps running; only the step restarts.
                                step_data_d = start_step_q;
                                step_vld_d  = 1'b1;
                                state_d     = StStep;
                            end
                            ModeTri: begin
                                up_d        = !up_q;
                                rev_d       = !rev_q;
                                step_data_d = next_rev;
                                step_vld_d  = 1'b1;
                                state_d     = StStep;
                            end
                            default: begin
                                state_d = StDone;
                            end
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_WIDTH'(1);
                end
            end

            StStep: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (step_hs) begin
                    cur_step_d = step_data_q;
                    if (abort || abort_pend_q) begin
                        state_d      = StHalt;
                        step_data_d  = '0;
                        abort_pend_d = 1'b0;
                    end else begin
                        step_vld_d = 1'b0;
                        state_d    = StDwell;
                        cnt_d      = dwell_init;
                    end
                end
            end

            StDone: begin
                if (abort) begin
                    state_d     = StHalt;
                    step_data_d = '0;
                    step_vld_d  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end

            StHalt: begin
                if (step_hs) begin
                    step_vld_d = 1'b0;
                    cur_step_d = '0;
                    state_d    = StIdle;
                end
            end

            default: begin
                state_d     = StIdle;
                phase_vld_d = 1'b0;
                step_vld_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mode_q       <= ModeSingle;
            init_phase_q <= '0;
            start_step_q <= '0;
            stop_step_q  <= '0;
            delta_q      <= '0;
            dwell_q      <= '0;
            cnt_q        <= '0;
            step_data_q  <= '0;
            cur_step_q   <= '0;
            up_q         <= 1'b0;
            rev_q        <= 1'b0;
            phase_vld_q  <= 1'b0;
            step_vld_q   <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            init_phase_q <= init_phase_d;
            start_step_q <= start_step_d;
            stop_step_q  <= stop_step_d;
            delta_q      <= delta_d;
            dwell_q      <= dwell_d;
            cnt_q        <= cnt_d;
            step_data_q  <= step_data_d;
            cur_step_q   <= cur_step_d;
            up_q         <= up_d;
            rev_q        <= rev_d;
            phase_vld_q  <= phase_vld_d;
            step_vld_q   <= step_vld_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign output_phase_tdata       = init_phase_q;
    assign output_phase_tvalid      = phase_vld_q;
    assign output_phase_step_tdata  = step_data_q;
    assign output_phase_step_tvalid = step_vld_q;
    assign busy                     = (state_q != StIdle);
    assign done                     = (state_q == StDone);
    assign cur_step                 = cur_step_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed testbench for dds_sweep_ctrl: every accepted phase / phase-step transfer and every
// done pulse is logged, and each scenario compares the log against hand-computed sequences.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_init_phase, cfg_start_step, cfg_stop_step, cfg_delta;
    logic [15:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic        start, abort;
    logic [31:0] output_phase_tdata;
    logic        output_phase_tvalid, output_phase_tready;
    logic [31:0] output_phase_step_tdata;
    logic        output_phase_step_tvalid, output_phase_step_tready;
    logic        busy, done;
    logic [31:0] cur_step;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(
        .PHASE_WIDTH (32),
        .DWELL_WIDTH (16)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .cfg_init_phase           (cfg_init_phase),
        .cfg_start_step           (cfg_start_step),
        .cfg_stop_step            (cfg_stop_step),
        .cfg_delta                (cfg_delta),
        .cfg_dwell                (cfg_dwell),
        .cfg_mode                 (cfg_mode),
        .start                    (start),
        .abort                    (abort),
        .output_phase_tdata       (output_phase_tdata),
        .output_phase_tvalid      (output_phase_tvalid),
        .output_phase_tready      (output_phase_tready),
        .output_phase_step_tdata  (output_phase_step_tdata),
        .output_phase_step_tvalid (output_phase_step_tvalid),
        .output_phase_step_tready (output_phase_step_tready),
        .busy                     (busy),
        .done                     (done),
        .cur_step                 (cur_step)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    logic [31:0] steps[$];
    int          step_cyc[$];
    logic [31:0] phases[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (output_phase_step_tvalid && output_phase_step_tready) begin
                steps.push_back(output_phase_step_tdata);
                step_cyc.push_back(cyc);
            end
            if (output_phase_tvalid && output_phase_tready) begin
                phases.push_back(output_phase_tdata);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] ip, input logic [31:0] st, input logic [31:0] sp,
                           input logic [31:0] dl, input logic [15:0] dw, input logic [1:0] md);
        cfg_init_phase = ip;
        cfg_start_step = st;
        cfg_stop_step  = sp;
        cfg_delta      = dl;
        cfg_dwell      = dw;
        cfg_mode       = md;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic wait_steps(input string tag, input int sb, input int n, input int budget);
        for (int k = 0; k < budget && steps.size() < sb + n; k++) tick();
        check({tag, "_nsteps"}, 64'(steps.size() >= sb + n), 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int k = 0; k < budget && busy; k++) tick();
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] step_at(input int idx);
        return (idx < steps.size()) ? steps[idx] : 32'hDEAD_BEEF;
    endfunction

    task automatic check_steps(input string tag, input int sb, input logic [31:0] exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s_step%0d", tag, i), 64'(step_at(sb + i)), 64'(exp[i]));
        end
    endtask

    task automatic check_gap(input string tag, input int idx, input int exp_gap);
        int gap;
        gap = (idx + 1 < step_cyc.size()) ? step_cyc[idx + 1] - step_cyc[idx] : -1;
        check(tag, 64'(gap), 64'(exp_gap));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sb, pb, db;
        logic [31:0] exp[$];

        rst_n                    = 1'b0;
        start                    = 1'b0;
        abort                    = 1'b0;
        output_phase_tready      = 1'b1;
        output_phase_step_tready = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 2'b00);
        repeat (3) tick();

        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_phase_valid", 64'(output_phase_tvalid), 0);
        check("rst_step_valid", 64'(output_phase_step_tvalid), 0);
        check("rst_cur_step", 64'(cur_step), 0);
        check("rst_step_data", 64'(output_phase_step_tdata), 0);
        check("rst_phase_data", 64'(output_phase_tdata), 0);
        rst_n = 1'b1;
        tick();

        // Single sweep up, dwell 3: steps spaced 4 cycles.
        set_cfg(0, 100, 130, 10, 3, 2'b00);
        sb = steps.size(); pb = phases.size(); db = done_cnt;
        pulse_start();
        check("single_busy_load", 64'(busy), 1);
        wait_idle("single", 100);
        exp = {32'd100, 32'd110, 32'd120, 32'd130};
        check_steps("single", sb, exp);
        check("single_count", 64'(steps.size() - sb), 4);
        for (int i = 0; i < 3; i++) check_gap($sformatf("single_gap%0d", i), sb + i, 4);
        check("single_done", 64'(done_cnt - db), 1);
        check("single_phase_cnt", 64'(phases.size() - pb), 1);
        check("single_phase_val", 64'((phases.size() > pb) ? phases[pb] : 32'hDEAD_BEEF), 0);
        check("single_cur_step", 64'(cur_step), 130);

        // Clamp onto a stop value that is not a multiple of delta.
        set_cfg(0, 100, 125, 10, 1, 2'b00);
        sb = steps.size();
        pulse_start();
        wait_idle("clamp", 100);
        exp = {32'd100, 32'd110, 32'd120, 32'd125};
        check_steps("clamp", sb, exp);
        check("clamp_count", 64'(steps.size() - sb), 4);

        // Carry out of the top bit clamps; dwell 0 behaves as 1.
        set_cfg(0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 2'b00);
        sb = steps.size(); db = done_cnt;
        pulse_start();
        wait_idle("ovf", 100);
        exp = {32'hFFFF_FFF0, 32'hFFFF_FFFF};
        check_steps("ovf", sb, exp);
        check("ovf_count", 64'(steps.size() - sb), 2);
        check_gap("ovf_gap", sb, 2);
        check("ovf_done", 64'(done_cnt - db), 1);

        // Triangle starting downwards, then abort while dwelling.
        set_cfg(32'h1234, 20, 0, 10, 5, 2'b10);
        sb = steps.size(); pb = phases.size(); db = done_cnt;
        pulse_start();
        wait_steps("tri", sb, 6, 200);
        exp = {32'd20, 32'd10, 32'd0, 32'd10, 32'd20, 32'd10};
        check_steps("tri", sb, exp);
        check("tri_phase_val", 64'((phases.size() > pb) ? phases[pb] : 32'hDEAD_BEEF), 32'h1234);
        tick();
        pulse_abort();
        wait_idle("tri_abort", 50);
        check("tri_abort_count", 64'(steps.size() - sb), 7);
        check("tri_abort_zero", 64'(step_at(sb + 6)), 0);
        check("tri_abort_no_done", 64'(done_cnt - db), 0);
        check("tri_abort_cur_step", 64'(cur_step), 0);

        // Backpressure on the second step for 5 cycles.
        set_cfg(0, 100, 130, 10, 3, 2'b00);
        sb = steps.size();
        pulse_start();
        wait_steps("bp_first", sb, 1, 20);
        output_phase_step_tready = 1'b0;
        for (int k = 0; k < 20 && !output_phase_step_tvalid; k++) tick();
        check("bp_valid_up", 64'(output_phase_step_tvalid), 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", k), 64'(output_phase_step_tvalid), 1);
            check($sformatf("bp_hold_data%0d", k), 64'(output_phase_step_tdata), 110);
        end
        check("bp_no_accept", 64'(steps.size() - sb), 1);
        output_phase_step_tready = 1'b1;
        wait_steps("bp_rest", sb, 3, 30);
        check("bp_step1", 64'(step_at(sb + 1)), 110);
        check_gap("bp_gap_stalled", sb, 9);
        check_gap("bp_gap_after", sb + 1, 4);
        wait_idle("bp", 100);

        // Sawtooth: phase loaded once, step wraps back to start.
        set_cfg(32'h55, 0, 20, 10, 1, 2'b01);
        sb = steps.size(); pb = phases.size(); db = done_cnt;
        pulse_start();
        wait_steps("saw", sb, 9, 100);
        exp = {32'd0, 32'd10, 32'd20, 32'd0, 32'd10, 32'd20};
        check_steps("saw", sb, exp);
        check("saw_phase_cnt", 64'(phases.size() - pb), 1);
        check("saw_phase_val", 64'((phases.size() > pb) ? phases[pb] : 32'hDEAD_BEEF), 32'h55);
        pulse_abort();
        wait_idle("saw_abort", 50);
        check("saw_abort_zero", 64'(step_at(steps.size() - 1)), 0);
        check("saw_abort_no_done", 64'(done_cnt - db), 0);

        // Start and cfg changes mid-sweep are ignored.
        set_cfg(0, 100, 130, 10, 3, 2'b00);
        sb = steps.size(); db = done_cnt;
        pulse_start();
        wait_steps("swb_first", sb, 1, 20);
        set_cfg(7, 500, 900, 50, 1, 2'b01);
        pulse_start();
        wait_idle("swb", 200);
        exp = {32'd100, 32'd110, 32'd120, 32'd130};
        check_steps("swb", sb, exp);
        check("swb_count", 64'(steps.size() - sb), 4);
        check_gap("swb_gap", sb + 1, 4);
        check("swb_done", 64'(done_cnt - db), 1);

        // Reset while dwelling clears everything at once.
        set_cfg(0, 100, 130, 10, 8, 2'b00);
        sb = steps.size();
        pulse_start();
        wait_steps("rstd_first", sb, 1, 20);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rstd_busy", 64'(busy), 0);
        check("rstd_step_valid", 64'(output_phase_step_tvalid), 0);
        check("rstd_cur_step", 64'(cur_step), 0);
        check("rstd_step_data", 64'(output_phase_step_tdata), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset while the phase load is stalled drops tvalid immediately.
        output_phase_tready = 1'b0;
        pulse_start();
        check("rstl_valid_before", 64'(output_phase_tvalid), 1);
        rst_n = 1'b0;
        #1;
        check("rstl_valid_after", 64'(output_phase_tvalid), 0);
        tick();
        rst_n = 1'b1;
        output_phase_tready = 1'b1;
        tick();

        // A normal sweep after the resets.
        set_cfg(0, 100, 130, 10, 3, 2'b00);
        sb = steps.size(); db = done_cnt;
        pulse_start();
        wait_idle("post", 100);
        exp = {32'd100, 32'd110, 32'd120, 32'd130};
        check_steps("post", sb, exp);
        check("post_done", 64'(done_cnt - db), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
